pipelined_borrow_skip_subtractor: RTL and testbench
===================================================

Name: pipelined_borrow_skip_subtractor

Overview:
Pipelined 32-bit subtractor computing Diff = A - B - Bin. It is the subtraction counterpart to the team's combinational carry-skip adder. The block is split into 8-bit groups, one group per pipeline stage, and a group-level borrow skip bypasses the ripple when every bit in a group propagates. Valid/ready handshakes on input and output let it sit between the operand source and the ALU result bus with full backpressure.

Parameters:
WIDTH, 32, operand and result width; must be an integer multiple of GROUP.
GROUP, 8, bits resolved per pipeline stage.
STAGES, WIDTH/GROUP (4), number of pipeline stages; derived, not overridable.

Ports:
clk        input   1      single clock; all logic on rising edge
rst_n      input   1      synchronous, active-low reset
in_valid   input   1      operand beat valid
in_ready   output  1      block can accept a beat this cycle
A          input   WIDTH  minuend
B          input   WIDTH  subtrahend
Bin        input   1      borrow in
out_valid  output  1      result beat valid
out_ready  input   1      downstream accepts result this cycle
Diff       output  WIDTH  A - B - Bin, modulo 2^WIDTH
Bout       output  1      borrow out; 1 iff A < B + Bin, unsigned
Ovf        output  1      signed overflow
Zero       output  1      Diff == 0

Behaviour:
- Reset: the block samples rst_n low on a clk edge. Every stage valid clears, and Diff, Bout, Ovf, Zero and out_valid all become 0. in_ready is forced to 0 while rst_n is low. Reset mid-operation discards all in-flight beats, and none reach the output.
- Accept: a beat is taken on an edge where in_valid && in_ready. A, B and Bin are captured in the same cycle.
- Stage k (k = 0..STAGES-1) resolves bits [k*GROUP +: GROUP] from the operands carried in its upstream register and the borrow from stage k-1 (Bin for stage 0).
  - It registers the partial Diff bits, the borrow out, and the unprocessed upper operand bits.
  - Per bit: generate g = ~a & b; propagate p = ~(a ^ b); d = a ^ b ^ borrow_in_bit; borrow_next = g | (p & borrow_in_bit).
  - Group skip: when every p in the group is 1, the group borrow out equals the group borrow in, bypassing the ripple. The result must equal the pure ripple result in all cases.
- Output is the last stage register.
  - Ovf = (A[W-1] ^ B[W-1]) & (A[W-1] ^ Diff[W-1]), using the original operand MSBs, which are carried through the pipeline.
  - Zero = ~|Diff.
- Latency: accepted on edge n, the result is visible with out_valid = 1 after edge n+3 (STAGES cycles including the capture edge). Throughput is one beat per cycle when out_ready is held high.
- Stage handshake, bubble-collapsing:
  - stage_ready[k] = ~stage_valid[k] | stage_ready[k+1].
  - stage_ready[STAGES] = out_ready.
  - in_ready = stage_ready[0] & rst_n.
  - A stage loads when its own ready is high. Its valid takes the upstream valid, or in_valid for stage 0.
- Stall: when out_valid && ~out_ready, Diff, Bout, Ovf and Zero hold stable. Upstream stages keep filling bubbles until all stages are valid, and then in_ready drops.
- Simultaneous events:
  - Output pop and input push in the same cycle are both honoured. No beat is lost, duplicated or reordered.
  - Reset has priority over any handshake.
- Arithmetic rules:
  - Results are modulo 2^WIDTH, with no saturation.
  - Bin = 1 with A = B gives Diff = all-ones, Bout = 1.
- Outputs are fully registered, so there is no combinational path from A/B to Diff. in_ready is a combinational function of the stage valids and out_ready.

Test Plan:
1. Basic subtraction: A=0x00000005, B=0x00000003, Bin=0, out_ready=1. Required: after 4 cycles, Diff=0x00000002, Bout=0, Ovf=0, Zero=0, and out_valid high for exactly 1 cycle.
2. Full borrow ripple through all skip groups: A=0x00000000, B=0x00000001, Bin=0. Required: Diff=0xFFFFFFFF, Bout=1, Ovf=0, Zero=0.
3. Signed overflow: A=0x80000000, B=0x00000001, Bin=0. Required: Diff=0x7FFFFFFF, Ovf=1, Bout=0.
4. Borrow-in to zero: A=0x12345678, B=0x12345677, Bin=1. Required: Diff=0x00000000, Zero=1, Bout=0, Ovf=0.
5. Backpressure: stream 6 back-to-back beats (A=i+10, B=i, i=0..5) and hold out_ready low for 3 cycles starting at the first out_valid.
   - in_ready drops once 4 beats are in flight.
   - All 6 results emerge in order with Diff=10, no drops or duplicates.
   - Diff stays stable while stalled.
6. Reset mid-flight: issue 3 beats, then hold rst_n low for 1 cycle. Required:
   - out_valid=0 and all outputs 0 on the next cycle.
   - None of the 3 results ever appear.
   - A new beat accepted after reset returns its correct result 4 cycles later.

Source files
------------

// File: rtl/pipelined_borrow_skip_subtractor.sv
// -----------------------------------------------------------------------------
// pipelined_borrow_skip_subtractor
//
// Pipelined unsigned/two's-complement subtractor: Diff = A - B - Bin, modulo
// 2^WIDTH. The operand is split into GROUP-bit groups and each pipeline stage
// resolves one group, so a beat accepted on edge n is presented at the output
// after edge n+STAGES-1. Inside each group the borrow ripples bit by bit. A
// group whose bits all propagate (a == b) hands its incoming borrow straight
// to the next group instead of waiting for the ripple.
//
// Every stage only keeps what later stages still need:
//   - the diff bits resolved so far (grows by GROUP bits per stage);
//   - the borrow into the next group;
//   - the operand bits not yet consumed (shrinks by GROUP bits per stage).
// The operand MSBs used for signed overflow are the top bits of the unconsumed
// operand slice, so they reach the last stage without extra state.
//
// Handshake is bubble-collapsing: a stage accepts new data whenever it is
// empty or its successor is accepting. in_ready therefore drops only when every
// stage holds a beat and the output is stalled.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset; flushes all in-flight beats
//   in_valid   in   operand beat valid
//   in_ready   out  block accepts a beat this cycle (0 while rst_n is low)
//   A, B       in   minuend / subtrahend, WIDTH bits
//   Bin        in   borrow in
//   out_valid  out  result beat valid
//   out_ready  in   downstream accepts the result this cycle
//   Diff       out  A - B - Bin modulo 2^WIDTH
//   Bout       out  borrow out (A < B + Bin, unsigned)
//   Ovf        out  signed overflow of the subtraction
//   Zero       out  Diff == 0
//
// WIDTH must be an integer multiple of GROUP.
// -----------------------------------------------------------------------------
module pipelined_borrow_skip_subtractor #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8,
    localparam int STAGES = WIDTH / GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    // stage_ready[k] is the load enable of stage k; the extra top entry is the
    // downstream acceptance.
    logic [STAGES:0] stage_ready;

    assign stage_ready[STAGES] = out_ready;

    // Reset overrides any handshake, so nothing is taken while rst_n is low.
    assign in_ready = stage_ready[0] & rst_n;

    for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
        localparam int LO  = gi * GROUP;   // first bit resolved here
        localparam int REM = WIDTH - LO;   // operand bits still unconsumed

        // Upstream view: operands, borrow, partial diff and valid.
        logic [REM-1:0]      src_a;
        logic [REM-1:0]      src_b;
        logic                src_bin;
        logic                src_valid;
        logic [LO+GROUP-1:0] d_next;

        // Group arithmetic.
        logic [GROUP-1:0]    grp_a;
        logic [GROUP-1:0]    grp_b;
        logic [GROUP-1:0]    grp_p;
        logic [GROUP-1:0]    grp_g;
        logic [GROUP-1:0]    grp_d;
        logic [GROUP:0]      chain;
        logic                grp_skip;
        logic                grp_bout;

        // Stage register.
        logic                vld_q;
        logic                brw_q;
        logic [LO+GROUP-1:0] d_q;

        if (gi == 0) begin : g_src
            assign src_a     = A;
            assign src_b     = B;
            assign src_bin   = Bin;
            assign src_valid = in_valid;
            assign d_next    = grp_d;
        end else begin : g_src
            assign src_a     = gen_stage[gi-1].g_ops.a_q;
            assign src_b     = gen_stage[gi-1].g_ops.b_q;
            assign src_bin   = gen_stage[gi-1].brw_q;
            assign src_valid = gen_stage[gi-1].vld_q;
            assign d_next    = {grp_d, gen_stage[gi-1].d_q};
        end

        assign grp_a = src_a[GROUP-1:0];
        assign grp_b = src_b[GROUP-1:0];

        // A borrow is generated where a=0,b=1 and passed on where a==b.
        assign grp_p = ~(grp_a ^ grp_b);
        assign grp_g = ~grp_a & grp_b;

        // Bit-level ripple; it also produces the difference bits, which need
        // the per-bit borrow regardless of the skip.
        always_comb begin
            chain    = '0;
            grp_d    = '0;
            chain[0] = src_bin;
            for (int i = 0; i < GROUP; i++) begin
                grp_d[i]     = grp_a[i] ^ grp_b[i] ^ chain[i];
                chain[i+1]   = grp_g[i] | (grp_p[i] & chain[i]);
            end
        end

        // When every bit propagates the ripple output is necessarily the
        // incoming borrow, so the skip path gives the same answer without
        // depending on the GROUP-deep chain.
        assign grp_skip = &grp_p;
        assign grp_bout = grp_skip ? src_bin : chain[GROUP];

        // Bubble-collapsing ready: an empty stage can always load.
        assign stage_ready[gi] = ~vld_q | stage_ready[gi+1];

        // Data only moves when a real beat arrives, so a stalled or drained
        // output keeps showing its last result.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                brw_q <= 1'b0;
                d_q   <= '0;
            end else if (stage_ready[gi]) begin
                vld_q <= src_valid;
                if (src_valid) begin
                    brw_q <= grp_bout;
                    d_q   <= d_next;
                end
            end
        end

        if (gi < STAGES - 1) begin : g_ops
            // Operand bits above this group, handed to the next stage.
            logic [REM-GROUP-1:0] a_q;
            logic [REM-GROUP-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (stage_ready[gi] && src_valid) begin
                    a_q <= src_a[REM-1:GROUP];
                    b_q <= src_b[REM-1:GROUP];
                end
            end
        end else begin : g_last
            // Flags are resolved alongside the top group so the outputs come
            // straight from flops. grp_a/grp_b hold the original MSBs here.
            logic ovf_q;
            logic zero_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (stage_ready[gi] && src_valid) begin
                    ovf_q  <= (grp_a[GROUP-1] ^ grp_b[GROUP-1]) &
                              (grp_a[GROUP-1] ^ d_next[WIDTH-1]);
                    zero_q <= ~|d_next;
                end
            end
        end
    end

    assign out_valid = gen_stage[STAGES-1].vld_q;
    assign Diff      = gen_stage[STAGES-1].d_q;
    assign Bout      = gen_stage[STAGES-1].brw_q;
    assign Ovf       = gen_stage[STAGES-1].g_last.ovf_q;
    assign Zero      = gen_stage[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_borrow_skip_subtractor.sv
// -----------------------------------------------------------------------------
// Testbench for pipelined_borrow_skip_subtractor.
// A negedge monitor keeps a queue of expected results computed with plain
// wide arithmetic. It checks every presented result in order, and it checks
// in_ready against pipeline occupancy. Directed sections cover the listed
// corner cases, backpressure and mid-flight reset. A randomized section
// exercises random operands with random valid/ready timing.
// -----------------------------------------------------------------------------
module tb_pipelined_borrow_skip_subtractor;

    localparam int W      = 32;
    localparam int STAGES = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         Ovf;
    logic         Zero;

    pipelined_borrow_skip_subtractor #(.WIDTH(W), .GROUP(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Ovf       (Ovf),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pops = 0;
    bit   saw_full = 1'b0;
    bit   mon_en = 1'b0;
    bit   rnd_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, no bit-level borrow logic.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        res_t        r;
        logic [W:0]  wide;
        longint      sd;
        wide   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        r.diff = wide[W-1:0];
        r.bout = wide[W];      // set exactly when the true result is negative
        sd     = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        r.ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        r.zero = (r.diff == '0);
        return r;
    endfunction

    // Monitor: one sample per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    check("diff", {32'd0, Diff}, {32'd0, exp_q[0].diff});
                    check("bout", {63'd0, Bout}, {63'd0, exp_q[0].bout});
                    check("ovf",  {63'd0, Ovf},  {63'd0, exp_q[0].ovf});
                    check("zero", {63'd0, Zero}, {63'd0, exp_q[0].zero});
                end
            end
            // The pipe refuses input only when all stages hold a beat and the
            // output is stalled, and never during reset.
            check("in_ready", {63'd0, in_ready},
                  {63'd0, rst_n && ((exp_q.size() < STAGES) || out_ready)});
            if (rst_n && !in_ready) saw_full = 1'b1;
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
                if (in_valid && in_ready) exp_q.push_back(model(A, B, Bin));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is accepted (bounded).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int n;
        bit hs;
        n = 0;
        hs = 1'b0;
        A = a;
        B = b;
        Bin = bin;
        in_valid = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = in_ready;
            step();
            n++;
        end
        if (!hs) check("send_timeout", {63'd0, hs}, 64'd1);
        in_valid = 1'b0;
    endtask

    // Edges from the accepting edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // Directed corner cases with hand-derived results.
    logic [W-1:0] t_a    [4] = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000, 32'h1234_5678};
    logic [W-1:0] t_b    [4] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h1234_5677};
    logic         t_bin  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] t_diff [4] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000};
    logic         t_bout [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic         t_ovf  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic         t_zero [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int pops0;
        int mode;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset
        rst_n = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        step();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_diff",      {32'd0, Diff},      64'd0);
        check("rst_bout",      {63'd0, Bout},      64'd0);
        check("rst_ovf",       {63'd0, Ovf},       64'd0);
        check("rst_zero",      {63'd0, Zero},      64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd0);
        rst_n = 1'b1;
        step();

        // Directed: basic, full ripple, overflow, borrow-in to zero
        for (int i = 0; i < 4; i++) begin
            send(t_a[i], t_b[i], t_bin[i]);
            wait_out(lat);
            check($sformatf("dir%0d_latency", i), 64'(lat), 64'd3);
            check($sformatf("dir%0d_diff", i), {32'd0, Diff}, {32'd0, t_diff[i]});
            check($sformatf("dir%0d_bout", i), {63'd0, Bout}, {63'd0, t_bout[i]});
            check($sformatf("dir%0d_ovf", i),  {63'd0, Ovf},  {63'd0, t_ovf[i]});
            check($sformatf("dir%0d_zero", i), {63'd0, Zero}, {63'd0, t_zero[i]});
            step();
            check($sformatf("dir%0d_single_valid", i), {63'd0, out_valid}, 64'd0);
        end

        // Backpressure: 6 beats, output stalled 3 cycles from first out_valid
        saw_full = 1'b0;
        pops0 = pops;
        fork
            begin
                for (int i = 0; i < 6; i++) send(W'(i + 10), W'(i), 1'b0);
            end
            begin
                int t;
                t = 0;
                while (!out_valid && t < 50) begin
                    step();
                    t++;
                end
                check("bp_first_valid", {63'd0, out_valid}, 64'd1);
                out_ready = 1'b0;
                repeat (3) step();
                out_ready = 1'b1;
            end
        join
        repeat (12) step();
        check("bp_in_ready_dropped", {63'd0, saw_full}, 64'd1);
        check("bp_pop_count", 64'(pops - pops0), 64'd6);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-flight: three beats discarded
        for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'b0);
        rst_n = 1'b0;
        pops0 = pops;
        step();
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_diff",      {32'd0, Diff},      64'd0);
        check("mid_rst_bout",      {63'd0, Bout},      64'd0);
        check("mid_rst_ovf",       {63'd0, Ovf},       64'd0);
        check("mid_rst_zero",      {63'd0, Zero},      64'd0);
        rst_n = 1'b1;
        repeat (8) step();
        check("mid_rst_no_ghosts", 64'(pops - pops0), 64'd0);
        send(32'hDEAD_0000, 32'h0000_0001, 1'b1);
        wait_out(lat);
        check("post_rst_latency", 64'(lat), 64'd3);
        check("post_rst_diff", {32'd0, Diff}, 64'h0000_0000_DEAC_FFFE);
        repeat (4) step();

        // Randomized: operand classes that stress skip/ripple, random timing
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    mode = $urandom_range(0, 4);
                    ra = W'($urandom);
                    rb = W'($urandom);
                    case (mode)
                        0: rb = ra;                                   // all groups propagate
                        1: rb = ra ^ (32'hFF << (8 * $urandom_range(0, 3)));
                        2: begin
                            ra = (mode[0] ? 32'h8000_0000 : 32'h7FFF_FFFF);
                            rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
                        end
                        3: ra = '0;
                        default: ;
                    endcase
                    send(ra, rb, 1'($urandom_range(0, 1)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    step();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) step();
        check("rnd_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
